hd_data_pattern: RTL and testbench
==================================

Name: hd_data_pattern

Overview:
- Test-data engine that sits between the faux SATA hard-drive model's data port and the testbench.
- Generator side supplies an incrementing word stream that the drive returns to the host on reads.
- Checker side verifies the word stream the host writes to the drive against the same incrementing pattern and flags a sticky error on any mismatch.
- Generator and checker are independent and each has its own enable.

Parameters:
- DATA_WIDTH, 32, width of data words and of the pattern counters.
- START_VALUE, 0, first pattern word after enable. Applies to both generator and checker.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_enable  input  1  generator enable (drive-to-host stream).
- hd_write_to_host  input  1  strobe: drive consumed hd_data_to_host this cycle.
- hd_data_to_host  output  DATA_WIDTH  current generator word.
- wr_count  output  24  words consumed since generator enable.
- rd_enable  input  1  checker enable (host-to-drive stream).
- hd_read_from_host  input  1  strobe: hd_data_from_host valid this cycle.
- hd_data_from_host  input  DATA_WIDTH  word written by host.
- rd_count  output  24  words checked since the last rising edge of rd_enable.
- error  output  1  sticky mismatch flag.

Behaviour:
- Reset values:
  - hd_data_to_host = START_VALUE.
  - wr_count = 0, rd_count = 0.
  - error = 0.
  - Internal expected register = START_VALUE.
  - Internal rd_enable_d (registered rd_enable) = 0.
- Generator:
  - hd_data_to_host is driven directly from a register; no combinational path from the strobe.
  - wr_enable=0: register <= START_VALUE and wr_count <= 0 every cycle. Strobes are ignored.
  - wr_enable=1 and hd_write_to_host=1: register <= register+1, modulo 2^DATA_WIDTH; wr_count <= wr_count+1. The new word is visible the next cycle.
  - wr_enable=1 and no strobe: everything holds.
  - The first word consumed after enable is always START_VALUE.
  - Back-to-back strobes on every cycle give consecutive values.
- Checker:
  - rd_enable_d is rd_enable delayed one cycle. Rise = rd_enable & ~rd_enable_d.
  - rd_enable=0: expected <= START_VALUE. Strobes are ignored. error and rd_count hold their values, so the bench can read results after disabling.
  - rd_enable=1 and hd_read_from_host=1: mismatch = (hd_data_from_host != expected); expected <= expected+1, modulo 2^DATA_WIDTH.
  - On mismatch the expected value does not resynchronise to the received data.
  - rd_count: cleared on rise, otherwise incremented per checked strobe. A strobe in the rise cycle gives rd_count=1.
  - error_next = (rise ? 0 : error) | (strobe-accepted & mismatch).
  - A strobe in the same cycle as the enable rise is checked against START_VALUE. A mismatch in that cycle sets error; the set wins over the clear.
- Wrap-around:
  - Pattern counters wrap from all-ones to 0 with no flag.
  - wr_count and rd_count wrap silently at 2^24.
- Reset mid-operation: asynchronous return to the reset values. The next enable restarts from START_VALUE.

Optional Feature:
- Macro: HD_DATA_ERR_CAPTURE_EN.
- With the macro defined, three extra outputs are added:
  - err_expected (DATA_WIDTH): expected word of the first mismatch since the last rise.
  - err_actual (DATA_WIDTH): received word of the first mismatch since the last rise.
  - err_index (24): value of rd_count before that strobe, i.e. zero-based word index.
  - All three are captured only when error transitions 0→1.
  - All three are reset to 0; they are not cleared on rise, only overwritten by the next capture.
- Without the macro these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, wr_enable=1, strobe 4 consecutive cycles → hd_data_to_host reads 0,1,2,3 on those cycles, then 4; wr_count=4.
- rd_enable=1, host writes 0..511 with gaps between strobes → error=0, rd_count=512.
- rd_enable=1, host writes 0,1,2,7,4 → error becomes 1 the cycle after word 7 and stays 1 through word 4 and after rd_enable drops. Capture build: err_expected=3, err_actual=7, err_index=3.
- After that error, drop rd_enable then raise it with a strobe of 0 in the rise cycle → error=0, rd_count=1. Raise again with a strobe of 5 in the rise cycle → error=1.
- START_VALUE=32'hFFFF_FFFE, generator strobed 3 times → hd_data_to_host sequence FFFF_FFFE, FFFF_FFFF, 0000_0000.
- Assert rst mid-stream with both enables high → outputs return to reset values immediately (asynchronously). After rst falls, the streams restart at START_VALUE.

Source files
------------

// File: rtl/hd_data_pattern.sv
// Incrementing-pattern generator (drive-to-host) and checker (host-to-drive) for the faux SATA drive model.
// Generator word is registered and advances the cycle after a strobe; the checker updates error/rd_count one cycle after a strobe. There is no backpressure: each strobe is consumed in the cycle it is asserted. Defining HD_DATA_ERR_CAPTURE_EN adds first-mismatch capture outputs.
module hd_data_pattern #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] START_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_enable,
   input  logic                  hd_write_to_host,
   output logic [DATA_WIDTH-1:0] hd_data_to_host,
   output logic [23:0]           wr_count,
   input  logic                  rd_enable,
   input  logic                  hd_read_from_host,
   input  logic [DATA_WIDTH-1:0] hd_data_from_host,
   output logic [23:0]           rd_count,
   output logic                  error
`ifdef HD_DATA_ERR_CAPTURE_EN
   ,
   output logic [DATA_WIDTH-1:0] err_expected,
   output logic [DATA_WIDTH-1:0] err_actual,
   output logic [23:0]           err_index
`endif
);

   logic [DATA_WIDTH-1:0] expected;
   logic                  rd_enable_d;
   logic                  rise;
   logic                  accept;
   logic                  mismatch;
   logic                  error_base;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hd_data_to_host <= START_VALUE;
         wr_count        <= 24'd0;
      end else if (!wr_enable) begin
         hd_data_to_host <= START_VALUE;
         wr_count        <= 24'd0;
      end else if (hd_write_to_host) begin
         hd_data_to_host <= hd_data_to_host + DATA_WIDTH'(1);
         wr_count        <= wr_count + 24'd1;
      end
   end

   // A rise clears the sticky error, but a mismatch in the same cycle still sets it.
   always_comb begin
      rise       = rd_enable & ~rd_enable_d;
      accept     = rd_enable & hd_read_from_host;
      mismatch   = accept && (hd_data_from_host != expected);
      error_base = rise ? 1'b0 : error;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_enable_d <= 1'b0;
         expected    <= START_VALUE;
         rd_count    <= 24'd0;
         error       <= 1'b0;
      end else begin
         rd_enable_d <= rd_enable;
         if (!rd_enable) begin
            expected <= START_VALUE;
         end else if (accept) begin
            expected <= expected + DATA_WIDTH'(1);
         end
         if (rise) begin
            rd_count <= accept ? 24'd1 : 24'd0;
         end else if (accept) begin
            rd_count <= rd_count + 24'd1;
         end
         error <= error_base | mismatch;
      end
   end

`ifdef HD_DATA_ERR_CAPTURE_EN
   // Capture only on the 0->1 transition so the first bad word since the last rise is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_expected <= '0;
         err_actual   <= '0;
         err_index    <= 24'd0;
      end else if (!error_base && mismatch) begin
         err_expected <= expected;
         err_actual   <= hd_data_from_host;
         err_index    <= rise ? 24'd0 : rd_count;
      end
   end
`endif

endmodule

// File: tb/tb_hd_data_pattern.sv
// Directed bench for hd_data_pattern: START_VALUE=0 instance for function/error/reset, START_VALUE=FFFF_FFFE instance for wrap.
module tb_hd_data_pattern;

   typedef struct packed {
      logic        err;
      logic [23:0] cnt;
   } rsp_t;

   logic        clk;
   logic        rst;
   logic        wr_enable, hd_write_to_host, rd_enable, hd_read_from_host;
   logic [31:0] hd_data_to_host, hd_data_from_host;
   logic [23:0] wr_count, rd_count;
   logic        error;
   logic        w_wr_enable, w_hd_write_to_host, w_rd_enable, w_hd_read_from_host;
   logic [31:0] w_hd_data_to_host, w_hd_data_from_host;
   logic [23:0] w_wr_count, w_rd_count;
   logic        w_error;
`ifdef HD_DATA_ERR_CAPTURE_EN
   logic [31:0] err_expected, err_actual, w_err_expected, w_err_actual;
   logic [23:0] err_index, w_err_index;
`endif

   int unsigned nvec  = 0;
   int unsigned nfail = 0;
   rsp_t        rq[$];
   logic [31:0] gq[$];
   logic [31:0] m_exp;
   logic [23:0] m_cnt;
   logic        m_err;
   logic [31:0] g_model;

   hd_data_pattern #(.DATA_WIDTH(32), .START_VALUE(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .wr_enable(wr_enable), .hd_write_to_host(hd_write_to_host),
      .hd_data_to_host(hd_data_to_host), .wr_count(wr_count),
      .rd_enable(rd_enable), .hd_read_from_host(hd_read_from_host),
      .hd_data_from_host(hd_data_from_host), .rd_count(rd_count),
      .error(error)
`ifdef HD_DATA_ERR_CAPTURE_EN
      , .err_expected(err_expected), .err_actual(err_actual), .err_index(err_index)
`endif
   );

   hd_data_pattern #(.DATA_WIDTH(32), .START_VALUE(32'hFFFF_FFFE)) dut_w (
      .clk(clk), .rst(rst),
      .wr_enable(w_wr_enable), .hd_write_to_host(w_hd_write_to_host),
      .hd_data_to_host(w_hd_data_to_host), .wr_count(w_wr_count),
      .rd_enable(w_rd_enable), .hd_read_from_host(w_hd_read_from_host),
      .hd_data_from_host(w_hd_data_from_host), .rd_count(w_rd_count),
      .error(w_error)
`ifdef HD_DATA_ERR_CAPTURE_EN
      , .err_expected(w_err_expected), .err_actual(w_err_actual), .err_index(w_err_index)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd_on();
      rd_enable = 1'b1;
      m_exp = 32'd0;
      m_cnt = 24'd0;
      m_err = 1'b0;
   endtask

   task automatic rd_off();
      rd_enable = 1'b0;
      tick();
      m_exp = 32'd0;
   endtask

   task automatic send(input logic [31:0] w);
      rsp_t r;
      hd_read_from_host = 1'b1;
      hd_data_from_host = w;
      if (w != m_exp) m_err = 1'b1;
      m_exp = m_exp + 32'd1;
      m_cnt = m_cnt + 24'd1;
      rq.push_back('{err: m_err, cnt: m_cnt});
      tick();
      hd_read_from_host = 1'b0;
      r = rq.pop_front();
      chk("rd_error", {31'd0, error}, {31'd0, r.err});
      chk("rd_count", {8'd0, rd_count}, {8'd0, r.cnt});
   endtask

   initial begin
      rst = 1'b1;
      wr_enable = 0; hd_write_to_host = 0; rd_enable = 0; hd_read_from_host = 0;
      hd_data_from_host = '0;
      w_wr_enable = 0; w_hd_write_to_host = 0; w_rd_enable = 0; w_hd_read_from_host = 0;
      w_hd_data_from_host = '0;
      m_exp = 0; m_cnt = 0; m_err = 0; g_model = 0;
      #3;
      chk("rst_data", hd_data_to_host, 32'h0);
      chk("rst_wr_count", {8'd0, wr_count}, 32'h0);
      chk("rst_rd_count", {8'd0, rd_count}, 32'h0);
      chk("rst_error", {31'd0, error}, 32'h0);
      chk("rst_w_data", w_hd_data_to_host, 32'hFFFF_FFFE);
      tick();
      rst = 1'b0;

      // Generator: four back-to-back strobes.
      wr_enable = 1'b1;
      tick();
      chk("gen_first", hd_data_to_host, 32'h0);
      for (int i = 0; i < 4; i++) begin
         hd_write_to_host = 1'b1;
         g_model = g_model + 32'd1;
         gq.push_back(g_model);
         tick();
         chk("gen_word", hd_data_to_host, gq.pop_front());
      end
      hd_write_to_host = 1'b0;
      tick();
      chk("gen_hold", hd_data_to_host, 32'd4);
      chk("gen_wr_count", {8'd0, wr_count}, 32'd4);

      // Disabled generator ignores strobes and restarts.
      wr_enable = 1'b0;
      hd_write_to_host = 1'b1;
      tick();
      hd_write_to_host = 1'b0;
      chk("gen_dis_data", hd_data_to_host, 32'h0);
      chk("gen_dis_count", {8'd0, wr_count}, 32'h0);

      // Checker: 512 good words with gaps.
      rd_on();
      tick();
      for (int i = 0; i < 512; i++) begin
         send(32'(i));
         repeat (i % 3) tick();
      end
      chk("rd_512_count", {8'd0, rd_count}, 32'd512);
      chk("rd_512_error", {31'd0, error}, 32'd0);
      rd_off();

      // Checker: one bad word in 0,1,2,7,4.
      rd_on();
      tick();
      chk("rd_rise_clear", {8'd0, rd_count}, 32'd0);
      send(32'd0); send(32'd1); send(32'd2); send(32'd7);
`ifdef HD_DATA_ERR_CAPTURE_EN
      chk("cap_expected", err_expected, 32'd3);
      chk("cap_actual", err_actual, 32'd7);
      chk("cap_index", {8'd0, err_index}, 32'd3);
`endif
      send(32'd4);
      rd_off();
      chk("err_sticky_off", {31'd0, error}, 32'd1);
      chk("count_hold_off", {8'd0, rd_count}, 32'd5);
`ifdef HD_DATA_ERR_CAPTURE_EN
      chk("cap_kept", err_actual, 32'd7);
`endif

      // Strobes in the rise cycle: good word clears, bad word sets.
      rd_on();
      send(32'd0);
      rd_off();
      rd_on();
      send(32'd5);
`ifdef HD_DATA_ERR_CAPTURE_EN
      chk("cap_rise_expected", err_expected, 32'd0);
      chk("cap_rise_actual", err_actual, 32'd5);
      chk("cap_rise_index", {8'd0, err_index}, 32'd0);
`endif

      // Wrap on the FFFF_FFFE instance.
      w_wr_enable = 1'b1;
      tick();
      chk("wrap_gen_0", w_hd_data_to_host, 32'hFFFF_FFFE);
      w_hd_write_to_host = 1'b1;
      tick();
      chk("wrap_gen_1", w_hd_data_to_host, 32'hFFFF_FFFF);
      tick();
      chk("wrap_gen_2", w_hd_data_to_host, 32'h0000_0000);
      tick();
      w_hd_write_to_host = 1'b0;
      chk("wrap_gen_3", w_hd_data_to_host, 32'h0000_0001);
      chk("wrap_wr_count", {8'd0, w_wr_count}, 32'd3);
      w_rd_enable = 1'b1;
      w_hd_read_from_host = 1'b1;
      w_hd_data_from_host = 32'hFFFF_FFFE; tick();
      w_hd_data_from_host = 32'hFFFF_FFFF; tick();
      w_hd_data_from_host = 32'h0000_0000; tick();
      w_hd_read_from_host = 1'b0;
      chk("wrap_rd_error", {31'd0, w_error}, 32'd0);
      chk("wrap_rd_count", {8'd0, w_rd_count}, 32'd3);

      // Asynchronous reset mid-stream with both enables high.
      wr_enable = 1'b1;
      hd_write_to_host = 1'b1;
      tick(); tick();
      hd_write_to_host = 1'b0;
      chk("pre_rst_error", {31'd0, error}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_data", hd_data_to_host, 32'h0);
      chk("arst_wr_count", {8'd0, wr_count}, 32'h0);
      chk("arst_rd_count", {8'd0, rd_count}, 32'h0);
      chk("arst_error", {31'd0, error}, 32'h0);
`ifdef HD_DATA_ERR_CAPTURE_EN
      chk("arst_cap_actual", err_actual, 32'h0);
`endif
      tick();
      rst = 1'b0;
      m_exp = 0; m_cnt = 0; m_err = 0;
      chk("post_rst_data", hd_data_to_host, 32'h0);
      hd_write_to_host = 1'b1;
      send(32'd0);
      hd_write_to_host = 1'b0;
      chk("post_rst_gen", hd_data_to_host, 32'd1);
      chk("post_rst_wr_count", {8'd0, wr_count}, 32'd1);
      send(32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
